// File: rtl/seg_scan_scheduler.sv
// Multiplexed 7-segment scan controller: shadow/active digit buffers, frame-boundary commit, per-slot blanking.
// Optional macro SEG_DIM_EN adds the bright port (PWM dimming of the SHOW period).
module seg_scan_scheduler #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       commit_req,
    output logic       commit_ack,
    output logic       frame_tick,
    output logic [7:0] segout,
    output logic [2:0] scanout
`ifdef SEG_DIM_EN
    ,
    input  logic [3:0] bright
`endif
);
    // Counter is at least 4 bits wide so the dimming compare always has slot_cnt[3:0].
    localparam int              CW        = (SCAN_DIV > 16) ? $clog2(SCAN_DIV) : 4;
    localparam logic [CW-1:0]   LAST_CNT  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]   BLANK_END = CW'(BLANK_CYC - 1);
    localparam logic [2:0]      LAST_DIG  = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;

    state_t          r_state, w_nxt_state;
    logic [CW-1:0]   r_cnt, w_nxt_cnt;
    logic [2:0]      r_digit, w_nxt_digit;
    logic            r_pending, w_nxt_pending;
    logic            r_ack, w_nxt_ack;
    logic            r_ftick, w_nxt_ftick;
    logic [7:0]      r_seg, w_nxt_seg;
    logic [2:0]      r_scan;
    logic [7:0]      r_shadow [8];
    logic [7:0]      r_active [8];
    logic            w_wr_fire;
    logic            w_lit;

    assign w_wr_fire = wr_valid & ~r_pending;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_digit = r_digit;
        if (!enable) begin
            w_nxt_state = ST_IDLE;
            w_nxt_cnt   = '0;
            w_nxt_digit = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_nxt_state = ST_BLANK;
                    w_nxt_cnt   = '0;
                    w_nxt_digit = '0;
                end
                ST_BLANK: begin
                    w_nxt_cnt = r_cnt + 1'b1;
                    if (r_cnt == BLANK_END)
                        w_nxt_state = ST_SHOW;
                end
                ST_SHOW: begin
                    if (r_cnt == LAST_CNT) begin
                        w_nxt_state = ST_BLANK;
                        w_nxt_cnt   = '0;
                        w_nxt_digit = (r_digit == LAST_DIG) ? 3'd0 : r_digit + 3'd1;
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_cnt   = '0;
                    w_nxt_digit = '0;
                end
            endcase
        end

        // Outputs are registered from the next-state view so they line up with r_state.
        w_nxt_pending = r_ack ? 1'b0 : (r_pending | commit_req);
        w_nxt_ftick   = (w_nxt_state == ST_SHOW) && (w_nxt_cnt == LAST_CNT) &&
                        (w_nxt_digit == LAST_DIG);
        w_nxt_ack     = w_nxt_pending && (w_nxt_ftick || (w_nxt_state == ST_IDLE));

`ifdef SEG_DIM_EN
        w_lit = (w_nxt_cnt[3:0] <= bright);
`else
        w_lit = 1'b1;
`endif
        w_nxt_seg = ((w_nxt_state == ST_SHOW) && w_lit) ? r_active[w_nxt_digit] : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_digit   <= '0;
            r_pending <= 1'b0;
            r_ack     <= 1'b0;
            r_ftick   <= 1'b0;
            r_seg     <= 8'hFF;
            r_scan    <= '0;
            for (int i = 0; i < 8; i++) begin
                r_shadow[i] <= 8'hFF;
                r_active[i] <= 8'hFF;
            end
        end else begin
            r_state   <= w_nxt_state;
            r_cnt     <= w_nxt_cnt;
            r_digit   <= w_nxt_digit;
            r_pending <= w_nxt_pending;
            r_ack     <= w_nxt_ack;
            r_ftick   <= w_nxt_ftick;
            r_seg     <= w_nxt_seg;
            r_scan    <= w_nxt_digit;
            // Out-of-range addresses complete the handshake but store nothing.
            if (w_wr_fire && ({1'b0, wr_addr} < 4'(NUM_DIGITS)))
                r_shadow[wr_addr] <= wr_data;
            // r_ack only rises with the frame's last cycle or in IDLE, never mid-frame.
            if (r_ack) begin
                for (int i = 0; i < 8; i++)
                    r_active[i] <= r_shadow[i];
            end
        end
    end

    assign wr_ready   = ~r_pending;
    assign commit_ack = r_ack;
    assign frame_tick = r_ftick;
    assign segout     = r_seg;
    assign scanout    = r_scan;

endmodule
